icache_traffic_checker: RTL and testbench

ICACHE_TRAFFIC_CHECKER -- requirements
Module: icache_traffic_checker

---
 rtl/icache_traffic_checker.sv | 108 ++++++++++
 tb/tb_icache_traffic_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_traffic_checker.sv
// icache_traffic_checker: issues a strided/jumping address stream to an icache and checks the returned data against an address-derived pattern
module icache_traffic_checker #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int HOLDOFF = 80,
  parameter int DISTANCE = 6,
  parameter int NUM_TESTS = 1000,
  parameter int DEPTH = 8,
  parameter int JUMP_PERIOD = 64,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [AW-1:0] addr_out,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [DW-1:0] data_in,
  output logic          test_ended,
  output logic          test_error,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr
);
  localparam int PW = $clog2(DEPTH);
  logic [15:0] hold_cnt;
  logic [7:0] gap_cnt;
  logic [19:0] req_cnt, resp_cnt, req_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic jsel;
  logic [AW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push, pop, empty, full, hold_done, gap_done, jump, err;
  logic [AW-1:0] lfsr_addr, jump_addr, next_addr, head;
  logic [DW-1:0] exp_data;
  assign ready_out = 1'b1;
  for (genvar k = 0; k < AW; k++) begin : g_lfsr
    assign lfsr_addr[k] = (k < 2) ? 1'b0 : lfsr_nx[k % 16];
  end
  for (genvar i = 0; i < DW; i++) begin : g_exp
    assign exp_data[i] = head[i % AW] ^ 1'((i / AW) % 2);
  end
  // request eligibility, next address and response checking
  always_comb begin
    hold_done = hold_cnt == 16'(HOLDOFF);
    gap_done = gap_cnt == 8'(DISTANCE);
    full = count == (PW+1)'(DEPTH);
    empty = count == '0;
    valid_out = ~rst & hold_done & gap_done & ~full & (req_cnt < 20'(NUM_TESTS));
    push = valid_out & ready_in;
    pop = valid_in & ~empty;
    head = fifo[rd_ptr];
    req_nx = req_cnt + 20'd1;
    jump = (req_nx & 20'(JUMP_PERIOD - 1)) == '0;
    lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    jump_addr = (MODE != 0) ? lfsr_addr : (jsel ? '0 : {1'b1, {(AW-1){1'b0}}});
    next_addr = jump ? jump_addr : addr_out + AW'(4);
    err = valid_in & (empty | (data_in != exp_data));
  end
  // scoreboard storage holds accepted addresses until their responses return
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= addr_out;
  end
  // generator, scoreboard pointers and error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      gap_cnt <= 8'(DISTANCE);
      req_cnt <= '0;
      resp_cnt <= '0;
      lfsr <= 16'hACE1;
      jsel <= 1'b0;
      addr_out <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      test_ended <= 1'b0;
      test_error <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
    end else begin
      if (!hold_done) hold_cnt <= hold_cnt + 16'd1;
      if (push) gap_cnt <= '0;
      else if (!gap_done) gap_cnt <= gap_cnt + 8'd1;
      if (push) begin
        req_cnt <= req_nx;
        addr_out <= next_addr;
        wr_ptr <= wr_ptr + PW'(1);
        if (jump) begin
          lfsr <= lfsr_nx;
          jsel <= ~jsel;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        resp_cnt <= resp_cnt + 20'd1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (pop && resp_cnt == 20'(NUM_TESTS - 1)) test_ended <= 1'b1;
      if (err) begin
        test_error <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!test_error) first_err_addr <= empty ? '0 : head;
      end
    end
  end
endmodule

// File: tb/tb_icache_traffic_checker.sv
// tb_icache_traffic_checker: directed, table-driven bench for icache_traffic_checker
module tb_icache_traffic_checker;
  typedef struct {logic [23:0] a; int due;} pend_t;
  typedef struct {int dut; int idx; logic [23:0] addr;} vec_t;
  logic clk = 0;
  int cyc = 0;
  int checks = 0, passed = 0;
  logic r0 = 1, r1 = 1, r2 = 1;
  logic ri0 = 1, ri1 = 0, ri2 = 1;
  logic rv0 = 0, rv1 = 0, rv2 = 0, inj0 = 0, corrupt0 = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic [15:0] d2 = 0;
  logic vo0, vo1, vo2, ro0, ro1, ro2, te0, te1, te2, er0, er1, er2;
  logic [23:0] ao0, ao1, fe0, fe1;
  logic [7:0] ao2, fe2;
  logic [15:0] ec0, ec1, ec2;
  pend_t q0[$], q1[$], q2[$];
  pend_t p0, p1, p2;
  logic [23:0] log0[1000], log1[40];
  logic [7:0] log2[70];
  int n0 = 0, n1 = 0, n2 = 0, rc0 = 0, last0 = 0, gapbad0 = 0;
  int out1 = 0, maxout1 = 0, fullbad1 = 0;
  vec_t tv[14];
  icache_traffic_checker dut0 (.clk(clk), .rst(r0), .valid_out(vo0), .ready_in(ri0), .addr_out(ao0),
    .valid_in(rv0 | inj0), .ready_out(ro0), .data_in(d0), .test_ended(te0), .test_error(er0),
    .err_count(ec0), .first_err_addr(fe0));
  icache_traffic_checker #(.MODE(1), .JUMP_PERIOD(4), .DISTANCE(0), .NUM_TESTS(40)) dut1 (
    .clk(clk), .rst(r1), .valid_out(vo1), .ready_in(ri1), .addr_out(ao1), .valid_in(rv1),
    .ready_out(ro1), .data_in(d1), .test_ended(te1), .test_error(er1), .err_count(ec1),
    .first_err_addr(fe1));
  icache_traffic_checker #(.AW(8), .DW(16), .HOLDOFF(0), .DISTANCE(0), .JUMP_PERIOD(128),
    .NUM_TESTS(70)) dut2 (
    .clk(clk), .rst(r2), .valid_out(vo2), .ready_in(ri2), .addr_out(ao2), .valid_in(rv2),
    .ready_out(ro2), .data_in(d2), .test_ended(te2), .test_error(er2), .err_count(ec2),
    .first_err_addr(fe2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [31:0] expd(logic [23:0] a, int aw, int dw);
    logic [31:0] r = '0;
    for (int i = 0; i < dw; i++) r[i] = a[i % aw] ^ ((i / aw) % 2 == 1);
    return r;
  endfunction
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // dut0 accept monitor: address log, gap spacing, response scheduling
  always @(negedge clk) begin
    if (r0) begin
      q0.delete();
      n0 = 0;
      rc0 = 0;
    end else if (vo0 && ri0) begin
      if (n0 < 1000) log0[n0] = ao0;
      if (n0 > 0 && cyc - last0 != 7) gapbad0++;
      last0 = cyc;
      n0++;
      q0.push_back('{ao0, cyc + 1});
    end
  end
  // dut0 responder with optional corruption of responses 3 and 7
  always @(posedge clk) begin
    #2;
    rv0 = 0;
    if (!r0 && q0.size() > 0 && q0[0].due <= cyc) begin
      p0 = q0.pop_front();
      rv0 = 1;
      d0 = expd(p0.a, 24, 32) ^ ((corrupt0 && (rc0 == 2 || rc0 == 6)) ? 32'd1 : 32'd0);
      rc0++;
    end
  end
  // dut1 monitor: outstanding tracking against the depth limit
  always @(negedge clk) begin
    if (r1) begin
      q1.delete();
      n1 = 0;
      out1 = 0;
    end else begin
      if (out1 >= 8 && vo1) fullbad1++;
      if (vo1 && ri1) begin
        if (n1 < 40) log1[n1] = ao1;
        n1++;
        out1++;
        q1.push_back('{ao1, cyc + 20});
      end
      if (rv1) out1--;
      if (out1 > maxout1) maxout1 = out1;
    end
  end
  // dut1 responder with 20-cycle latency
  always @(posedge clk) begin
    #2;
    rv1 = 0;
    if (!r1 && q1.size() > 0 && q1[0].due <= cyc) begin
      p1 = q1.pop_front();
      rv1 = 1;
      d1 = expd(p1.a, 24, 32);
    end
  end
  // dut2 monitor for the narrow-address wrap case
  always @(negedge clk) begin
    if (r2) begin
      q2.delete();
      n2 = 0;
    end else if (vo2 && ri2) begin
      if (n2 < 70) log2[n2] = ao2;
      n2++;
      q2.push_back('{{16'd0, ao2}, cyc + 1});
    end
  end
  // dut2 responder
  always @(posedge clk) begin
    #2;
    rv2 = 0;
    if (!r2 && q2.size() > 0 && q2[0].due <= cyc) begin
      p2 = q2.pop_front();
      rv2 = 1;
      d2 = 16'(expd(p2.a, 8, 16));
    end
  end
  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  // directed sequence
  initial begin
    int k, bad;
    logic [23:0] a, act;
    logic tog;
    tv = '{'{0, 0, 24'h0}, '{0, 1, 24'h4}, '{0, 63, 24'hFC}, '{0, 64, 24'h800000},
           '{0, 65, 24'h800004}, '{0, 128, 24'h0}, '{0, 192, 24'h800000},
           '{1, 3, 24'hC}, '{1, 4, 24'h705670}, '{1, 5, 24'h705674}, '{1, 8, 24'h38AB38},
           '{2, 63, 24'hFC}, '{2, 64, 24'h0}, '{2, 65, 24'h4}};
    step(3);
    @(negedge clk);
    chk("rst valid_out", vo0, 0);
    chk("rst addr_out", ao0, 0);
    chk("rst test_ended", te0, 0);
    chk("rst test_error", er0, 0);
    chk("rst err_count", ec0, 0);
    chk("rst first_err_addr", fe0, 0);
    chk("ready_out", ro0, 1);
    step(1);
    r0 = 0;
    r2 = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vo0) break;
    end
    chk("first valid_out cycle", k, 80);
    for (int t = 0; t < 10000 && !te0; t++) @(negedge clk);
    chk("run1 test_ended", te0, 1);
    chk("run1 test_error", er0, 0);
    chk("run1 err_count", ec0, 0);
    chk("run1 requests", n0, 1000);
    chk("run1 request spacing", gapbad0, 0);
    bad = 0;
    a = 0;
    tog = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) begin
        if (i % 64 == 0) begin
          a = tog ? 24'h0 : 24'h800000;
          tog = ~tog;
        end else a = a + 24'd4;
      end
      if (log0[i] !== a) bad++;
    end
    chk("run1 address model", bad, 0);
    chk("wrap test_ended", te2, 1);
    chk("wrap err_count", ec2, 0);
    step(1);
    inj0 = 1;
    step(1);
    inj0 = 0;
    @(negedge clk);
    chk("late response err_count", ec0, 1);
    chk("late response test_error", er0, 1);
    step(1);
    r0 = 1;
    corrupt0 = 1;
    step(2);
    r0 = 0;
    @(negedge clk);
    chk("rerst err_count", ec0, 0);
    for (int t = 0; t < 300 && rc0 != 3; t++) @(negedge clk);
    chk("corrupt latency before", ec0, 0);
    @(negedge clk);
    chk("corrupt latency after", ec0, 1);
    for (int t = 0; t < 300 && rc0 < 10; t++) @(negedge clk);
    step(2);
    @(negedge clk);
    chk("corrupt err_count", ec0, 2);
    chk("corrupt first_err_addr", fe0, 24'h8);
    chk("corrupt test_error", er0, 1);
    step(1);
    r0 = 1;
    corrupt0 = 0;
    step(2);
    r0 = 0;
    step(10);
    inj0 = 1;
    step(1);
    inj0 = 0;
    @(negedge clk);
    chk("empty resp err_count", ec0, 1);
    chk("empty resp first_err_addr", fe0, 0);
    chk("empty resp test_error", er0, 1);
    chk("empty resp holdoff valid", vo0, 0);
    step(1);
    r1 = 0;
    for (int t = 0; t < 200 && !vo1; t++) @(negedge clk);
    a = ao1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!vo1 || ao1 !== a) bad++;
    end
    chk("backpressure hold", bad, 0);
    chk("backpressure none accepted", n1, 0);
    step(1);
    ri1 = 1;
    step(1);
    ri1 = 0;
    @(negedge clk);
    chk("single accept count", n1, 1);
    chk("single accept addr", ao1, 24'h4);
    step(1);
    ri1 = 1;
    for (int t = 0; t < 2000 && !te1; t++) @(negedge clk);
    chk("depth test_ended", te1, 1);
    chk("depth max outstanding", maxout1, 8);
    chk("depth valid while full", fullbad1, 0);
    chk("depth err_count", ec1, 0);
    step(1);
    r1 = 1;
    step(2);
    r1 = 0;
    for (int t = 0; t < 300 && n1 < 10; t++) @(negedge clk);
    step(1);
    r1 = 1;
    step(2);
    @(negedge clk);
    chk("mid rst valid_out", vo1, 0);
    chk("mid rst addr_out", ao1, 0);
    chk("mid rst test_ended", te1, 0);
    chk("mid rst err_count", ec1, 0);
    step(1);
    r1 = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vo1) break;
    end
    chk("restart valid_out cycle", k, 80);
    for (int i = 0; i < 14; i++) begin
      act = tv[i].dut == 0 ? log0[tv[i].idx] : tv[i].dut == 1 ? log1[tv[i].idx] : {16'd0, log2[tv[i].idx]};
      chk($sformatf("addr dut%0d idx%0d", tv[i].dut, tv[i].idx), act, tv[i].addr);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
